gray_to_binary_tracker: RTL and testbench

//  Downstream consumer of the binary_to_gray stage. Registers an incoming Gray-coded word and decodes it to binary.

---
 rtl/gray_to_binary_tracker.sv | 99 +++++++++
 tb/tb_gray_to_binary_tracker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gray_to_binary_tracker.sv
// Gray-to-binary decode stage with a one-deep valid/ready output register and step tracking.
// Define GRAY_STEP_CHECK_EN to build the multi-bit step detector and saturating error counter.
module gray_to_binary_tracker #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             dir_up,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [WIDTH-1:0] WordOne = WIDTH'(1);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] prev_gray_q;
    logic             have_prev_q;
    logic             accept;
    logic [WIDTH-1:0] bin_in;
    logic [WIDTH-1:0] prev_bin;
    logic             dir_next;

    function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign out_valid = (state_q == StFull);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign bin_in    = gray_decode(gray_in);
    assign prev_bin  = gray_decode(prev_gray_q);
    // A +1 binary step is always a single-bit Gray step, so no popcount is needed here.
    assign dir_next  = have_prev_q && (bin_in == prev_bin + WordOne);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            bin_out     <= '0;
            dir_up      <= 1'b0;
            prev_gray_q <= '0;
            have_prev_q <= 1'b0;
        end else begin
            case (state_q)
                StEmpty: if (accept) state_q <= StFull;
                StFull:  if (out_ready && !accept) state_q <= StEmpty;
                default: state_q <= StEmpty;
            endcase
            if (accept) begin
                bin_out     <= bin_in;
                dir_up      <= dir_next;
                prev_gray_q <= gray_in;
                have_prev_q <= 1'b1;
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    localparam logic [ERR_W-1:0] CountOne = ERR_W'(1);

    logic [WIDTH-1:0] diff;
    logic             multi_bit;
    logic             err_next;

    assign diff      = gray_in ^ prev_gray_q;
    // Clearing the lowest set bit leaves something only when two or more bits differ.
    assign multi_bit = |(diff & (diff - WordOne));
    assign err_next  = have_prev_q && multi_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_err  <= 1'b0;
            err_count <= '0;
        end else if (accept) begin
            step_err <= err_next;
            if (err_next && (err_count != '1)) begin
                err_count <= err_count + CountOne;
            end
        end
    end
`else
    assign step_err  = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Directed bench for gray_to_binary_tracker (WIDTH=4, ERR_W=8); expectations follow
// whether GRAY_STEP_CHECK_EN is defined for the build.
module tb_gray_to_binary_tracker;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] gray_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] bin_out;
    logic       dir_up;
    logic       step_err;
    logic [7:0] err_count;

    int n_vec;
    int n_err;

`ifdef GRAY_STEP_CHECK_EN
    localparam bit ChkOn = 1'b1;
`else
    localparam bit ChkOn = 1'b0;
`endif

    gray_to_binary_tracker #(
        .WIDTH(4),
        .ERR_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .gray_in  (gray_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bin_out  (bin_out),
        .dir_up   (dir_up),
        .step_err (step_err),
        .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] bin, input logic dir,
                             input logic serr);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".bin"}, 32'(bin_out), 32'(bin));
        check({tag, ".dir"}, 32'(dir_up), 32'(dir));
        check({tag, ".serr"}, 32'(step_err), 32'(serr));
    endtask

    initial begin
        logic [3:0] g;
        int         exp_cnt;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        gray_in   = 4'b0000;
        tick();
        tick();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.bin", 32'(bin_out), 32'd0);
        check("rst.dir", 32'(dir_up), 32'd0);
        check("rst.serr", 32'(step_err), 32'd0);
        check("rst.cnt", 32'(err_count), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // Decode sweep through all 16 Gray codes in counting order.
        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            g       = 4'(i ^ (i >> 1));
            gray_in = g;
            tick();
            check_out($sformatf("sweep%0d", i), 4'(i), (i > 0), 1'b0);
        end
        check("sweep.cnt", 32'(err_count), 32'd0);
        check("sweep.in_ready", 32'(in_ready), 32'd1);

        // Wrap 15->0 counts up, 0->15 does not.
        gray_in = 4'b0000;
        tick();
        check_out("wrap_up", 4'd0, 1'b1, 1'b0);
        gray_in = 4'b1000;
        tick();
        check_out("wrap_dn", 4'd15, 1'b0, 1'b0);
        gray_in = 4'b0000;
        tick();
        check_out("wrap_up2", 4'd0, 1'b1, 1'b0);

        // Illegal two-bit jump 0000 -> 0011.
        gray_in = 4'b0011;
        tick();
        check_out("jump", 4'b0010, 1'b0, ChkOn);
        check("jump.cnt", 32'(err_count), ChkOn ? 32'd1 : 32'd0);

        // 300 further two-bit jumps alternating 0000 / 0011; counter saturates at 255.
        for (int j = 0; j < 300; j++) begin
            gray_in = (j % 2 == 0) ? 4'b0000 : 4'b0011;
            tick();
            exp_cnt = (j + 2 > 255) ? 255 : j + 2;
            check($sformatf("sat%0d.cnt", j), 32'(err_count), ChkOn ? 32'(exp_cnt) : 32'd0);
        end
        check("sat.serr", 32'(step_err), 32'(ChkOn));
        check("sat.bin", 32'(bin_out), 32'd2);

        // Drain, then load 0111 with the consumer stalled.
        in_valid = 1'b0;
        tick();
        check("drain.valid", 32'(out_valid), 32'd0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        gray_in   = 4'b0111;
        tick();
        check_out("bp_load", 4'b0101, 1'b0, 1'b0);
        gray_in = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("bp_hold%0d", k), 4'b0101, 1'b0, 1'b0);
            check($sformatf("bp_hold%0d.in_ready", k), 32'(in_ready), 32'd0);
        end
        check("bp.cnt", 32'(err_count), ChkOn ? 32'd255 : 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_release", 32'(in_ready), 32'd1);
        tick();
        check_out("bp_next", 4'b0110, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        check("bp_drain.valid", 32'(out_valid), 32'd0);
        tick();
        check("bp_nodup.valid", 32'(out_valid), 32'd0);

        // Reset while FULL, then 1111 must be treated as the first word.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        gray_in   = 4'b0100;
        tick();
        check_out("pre_rst", 4'b0111, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("mid_rst.valid", 32'(out_valid), 32'd0);
        check("mid_rst.cnt", 32'(err_count), 32'd0);
        check("mid_rst.bin", 32'(bin_out), 32'd0);
        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        gray_in   = 4'b1111;
        tick();
        check_out("post_rst", 4'b1010, 1'b0, 1'b0);
        check("post_rst.cnt", 32'(err_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
